// File: rtl/div_pkg.sv
// Shared widths, iteration count and FSM encoding for the 512/256 restoring divider.
package div_pkg;

  localparam int unsigned DIVIDEND_W = 512;
  localparam int unsigned DIVISOR_W  = 256;
  localparam int unsigned COUNT_W    = 9;
  localparam int unsigned LAST_ITER  = 511;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step_256.sv
// One restoring-division iteration: 257-bit trial subtract of the divisor from {pr, bit}.
module div_step_256
  import div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] pr,
  input  logic                 in_bit,
  input  logic [DIVISOR_W-1:0] dv,
  output logic [DIVISOR_W-1:0] next_pr_c,
  output logic                 qbit_c
);

  logic [DIVISOR_W:0]   t;
  logic [DIVISOR_W-1:0] diff;

  // pr < dv keeps t < 2*dv, so t-dv always fits in 256 bits and only the low half is subtracted.
  always_comb begin
    t         = {pr, in_bit};
    qbit_c    = (t >= {1'b0, dv});
    diff      = t[DIVISOR_W-1:0] - dv;
    next_pr_c = qbit_c ? diff : t[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/divider_512.sv
// Sequential 512/256 restoring divider with start/done handshake.
// Define DIV_QUOTIENT_EN to keep the 512-bit quotient register; otherwise quo is tied to 0.
module divider_512
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] in1,
  input  logic [DIVISOR_W-1:0]  in2,
  output logic [DIVISOR_W-1:0]  out,
  output logic [DIVIDEND_W-1:0] quo,
  output logic                  done,
  output logic                  busy,
  output logic                  div_zero
);

  state_t                state;
  logic [DIVIDEND_W-1:0] sr;
  logic [DIVISOR_W-1:0]  pr;
  logic [DIVISOR_W-1:0]  dv;
  logic [COUNT_W-1:0]    count;
  logic [DIVISOR_W-1:0]  next_pr_c;
  logic                  qbit_c;
  logic [DIVIDEND_W-1:0] sr_next;

  div_step_256 u_step (
    .pr        (pr),
    .in_bit    (sr[DIVIDEND_W-1]),
    .dv        (dv),
    .next_pr_c (next_pr_c),
    .qbit_c    (qbit_c)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign sr_next = {sr[DIVIDEND_W-2:0], qbit_c};

`ifndef DIV_QUOTIENT_EN
  assign quo = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      out      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
      count    <= '0;
      sr       <= '0;
      pr       <= '0;
      dv       <= '0;
`ifdef DIV_QUOTIENT_EN
      quo      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (in2 != '0) begin
              sr       <= in1;
              dv       <= in2;
              pr       <= '0;
              count    <= '0;
              div_zero <= 1'b0;
              state    <= CALC;
            end else begin
              out      <= in1[DIVISOR_W-1:0];
              div_zero <= 1'b1;
`ifdef DIV_QUOTIENT_EN
              quo      <= '1;
`endif
              state    <= DONE;
            end
          end
        end
        CALC: begin
          pr    <= next_pr_c;
          sr    <= sr_next;
          count <= count + COUNT_W'(1);
          if (count == COUNT_W'(LAST_ITER)) begin
            out   <= next_pr_c;
`ifdef DIV_QUOTIENT_EN
            quo   <= sr_next;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_512.sv
// Directed bench for divider_512: vector table plus reset-abort, held-start and back-to-back sequences.
module tb_divider_512;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [511:0] in1;
  logic [255:0] in2;
  logic [255:0] out;
  logic [511:0] quo;
  logic         done;
  logic         busy;
  logic         div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  divider_512 dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
    .out      (out),
    .quo      (quo),
    .done     (done),
    .busy     (busy),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] a;
    logic [255:0] b;
    logic [511:0] q;
    logic [255:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [511:0] exp_quo(input logic [511:0] q);
`ifdef DIV_QUOTIENT_EN
    return q;
`else
    return (q & 512'd0);
`endif
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; reports edges from accept to done.
  task automatic run_op(input logic [511:0] a, input logic [255:0] b,
                        output int lat, output bit busy_ok);
    in1 = a;
    in2 = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = busy;
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    if (done && busy) busy_ok = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [511:0] q, input logic [255:0] r,
                              input logic dz, input int lat, input int exp_lat, input bit busy_ok);
    chk({tag, "_lat"}, 512'(lat), 512'(exp_lat));
    chk({tag, "_out"}, 512'(out), 512'(r));
    chk({tag, "_quo"}, quo, exp_quo(q));
    chk({tag, "_dz"}, 512'(div_zero), 512'(dz));
    chk({tag, "_busy"}, 512'(busy_ok), 512'(1));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 512'(done), 512'(0));
  endtask

  initial begin
    int           lat;
    bit           bok;
    bit           saw_done;
    logic [511:0] ones512;
    logic [255:0] ones256;
    logic [255:0] ra, rb, rr;
    logic [511:0] prod;

    ones512 = '1;
    ones256 = '1;

    tbl[0] = '{512'd100, 256'd7, 512'd14, 256'd2, 1'b0, 513};
    tbl[1] = '{ones512, ones256, (512'd1 << 256) + 512'd1, 256'd0, 1'b0, 513};
    tbl[2] = '{512'd5, 256'd1 << 255, 512'd0, 256'd5, 1'b0, 513};
    tbl[3] = '{512'd1 << 200, 256'd1 << 200, 512'd1, 256'd0, 1'b0, 513};
    tbl[4] = '{{ones256, 256'h1234}, 256'd0, ones512, 256'h1234, 1'b1, 1};
    tbl[5] = '{512'd100, 256'd7, 512'd14, 256'd2, 1'b0, 513};
    tbl[6] = '{512'd19, 256'd5, 512'd3, 256'd4, 1'b0, 513};
    tbl[7] = '{512'd1 << 300, 256'd3, (512'd1 << 300) / 512'd3, 256'd1, 1'b0, 513};

    reset = 1'b1;
    start = 1'b0;
    in1 = '0;
    in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 512'(out), 512'd0);
    chk("rst_quo", quo, 512'd0);
    chk("rst_done", 512'(done), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_dz", 512'(div_zero), 512'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, lat, bok);
      check_result($sformatf("vec%0d", i), tbl[i].q, tbl[i].r, tbl[i].dz, lat, tbl[i].lat, bok);
    end

    // Dividends built as a*b+r with r<b must return quotient a, remainder r.
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 8; w++) begin
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
        rr[w*32 +: 32] = $urandom;
      end
      if (k == 1) rb = rb >> 130;
      rb[0] = 1'b1;
      rr = rr % rb;
      prod = 512'(ra) * 512'(rb) + 512'(rr);
      run_op(prod, rb, lat, bok);
      check_result($sformatf("rand%0d", k), 512'(ra), rr, 1'b0, lat, 513, bok);
    end

    // Abort at count=200; outputs from the previous result must be cleared.
    in1 = 512'd100;
    in2 = 256'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_out", 512'(out), 512'd0);
    chk("abort_quo", quo, 512'd0);
    chk("abort_done", 512'(done), 512'd0);
    chk("abort_busy", 512'(busy), 512'd0);
    chk("abort_dz", 512'(div_zero), 512'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (600) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 512'(saw_done), 512'd0);
    run_op(512'd100, 256'd7, lat, bok);
    check_result("after_abort", 512'd14, 256'd2, 1'b0, lat, 513, bok);

    // Start held high: ignored during CALC, then re-accepted right after done.
    in1 = 512'd100;
    in2 = 256'd7;
    start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    repeat (100) begin
      @(posedge clk); #1;
      lat++;
    end
    in1 = ones512;
    in2 = 256'd3;
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("held_lat", 512'(lat), 512'd513);
    chk("held_out", 512'(out), 512'd2);
    chk("held_quo", quo, exp_quo(512'd14));
    in1 = 512'd1 << 200;
    in2 = 256'd1 << 200;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 512'(busy), 512'd1);
    chk("b2b_done_low", 512'(done), 512'd0);
    lat = 0;
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat", 512'(lat), 512'd513);
    chk("b2b_out", 512'(out), 512'd0);
    chk("b2b_quo", quo, exp_quo(512'd1));
    chk("b2b_busy_fall", 512'(busy), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
